circ_seq_queue: RTL and testbench

Parametrised, multi-channel circular sample queue for the audio filter path. It holds the most recent DEPTH samples per channel. On each accepted sample while full, it streams the whole window oldest-to-newest, one sample per clock, to the downstream MAC. It generalises the fixed 1536x16 high-frequency queue with:
- configurable width, depth and channel count;
- optional 2:1 decimation, so the same block also serves the low-frequency queue;
- write-during-sequence protection with overrun reporting.

---
 rtl/circ_seq_queue.sv | 153 +++++++++++++++
 tb/tb_circ_seq_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/circ_seq_queue.sv
// rtl/circ_seq_queue.sv - multi-channel circular sample queue with windowed read-out
module circ_seq_queue #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 1536,
    parameter int CHANNELS = 2,
    parameter int DECIMATE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*DATA_W-1:0]   new_smpl,
    input  logic                         wrt_smpl,
    output logic [CHANNELS*DATA_W-1:0]   smpl_out,
    output logic                         sequencing,
    output logic                         smpl_last,
    output logic                         full,
    output logic                         overrun
);

    localparam int W  = CHANNELS * DATA_W;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);

    typedef enum logic {IDLE, READ} state_t;

    logic [W-1:0]  mem [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_v_q, pend_v_d;
    logic [W-1:0]  pend_q, pend_d;
    logic          phase_q, phase_d;
    logic          ovr_q, ovr_d;
    logic          seq_q, last_q;
    logic [W-1:0]  out_q;
    logic          acc;
    logic          we;
    logic [W-1:0]  wdata;
    logic          rd_en;

    // Pointer advance with explicit wrap so any DEPTH >= 2 works.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    // Next-state: accept/commit writes, walk the read window, track pending and overrun.
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rcnt_d   = rcnt_q;
        cnt_d    = cnt_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        phase_d  = phase_q ^ wrt_smpl;
        ovr_d    = 1'b0;
        we       = 1'b0;
        wdata    = new_smpl;
        rd_en    = 1'b0;
        acc      = wrt_smpl && ((DECIMATE == 0) || !phase_q);

        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    // Pending sample is committed first; a coincident accept refills the slot.
                    we       = 1'b1;
                    wdata    = pend_q;
                    pend_v_d = acc;
                    if (acc) pend_d = new_smpl;
                end else if (acc) begin
                    we = 1'b1;
                end
                if (we) begin
                    wptr_d = ptr_inc(wptr_q);
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    if (cnt_d == CNT_MAX) begin
                        state_d = READ;
                        rptr_d  = ptr_inc(wptr_q);
                        rcnt_d  = '0;
                    end
                end
            end
            READ: begin
                rd_en  = 1'b1;
                rptr_d = ptr_inc(rptr_q);
                rcnt_d = rcnt_q + AW'(1);
                if (rcnt_q == LAST_ADDR) state_d = IDLE;
                if (acc) begin
                    if (pend_v_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        pend_v_d = 1'b1;
                        pend_d   = new_smpl;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            rcnt_q   <= '0;
            cnt_q    <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            phase_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rcnt_q   <= rcnt_d;
            cnt_q    <= cnt_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            phase_q  <= phase_d;
            ovr_q    <= ovr_d;
        end
    end

    // Sample storage write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[wptr_q] <= wdata;
    end

    // Registered read port and output flags, one cycle behind each read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q  <= 1'b0;
            last_q <= 1'b0;
            out_q  <= '0;
        end else begin
            seq_q  <= rd_en;
            last_q <= rd_en && (rcnt_q == LAST_ADDR);
            if (rd_en) out_q <= mem[rptr_q];
        end
    end

    assign smpl_out   = out_q;
    assign sequencing = seq_q;
    assign smpl_last  = last_q;
    assign full       = (cnt_q == CNT_MAX);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_circ_seq_queue.sv
// tb/tb_circ_seq_queue.sv - self-checking bench for circ_seq_queue
module tb_circ_seq_queue;

    localparam int D  = 8;
    localparam int NC = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] data_a = '0;
    logic        wrt_a = 1'b0;
    logic [31:0] out_a;
    logic        seq_a, last_a, full_a, ovr_a;
    logic [15:0] data_b = '0;
    logic        wrt_b = 1'b0;
    logic [15:0] out_b;
    logic        seq_b, last_b, full_b, ovr_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Two channels, every sample stored.
    circ_seq_queue #(.DATA_W(16), .DEPTH(D), .CHANNELS(2), .DECIMATE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .new_smpl(data_a), .wrt_smpl(wrt_a),
        .smpl_out(out_a), .sequencing(seq_a), .smpl_last(last_a),
        .full(full_a), .overrun(ovr_a));

    // One channel, 2:1 decimation.
    circ_seq_queue #(.DATA_W(16), .DEPTH(D), .CHANNELS(1), .DECIMATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .new_smpl(data_b), .wrt_smpl(wrt_b),
        .smpl_out(out_b), .sequencing(seq_b), .smpl_last(last_b),
        .full(full_b), .overrun(ovr_b));

    always #5 clk = ~clk;

    // Model: history of stored samples and a per-cycle table of expected outputs.
    logic [31:0] hist  [2][256];
    int          m_n   [2];
    int          m_busy[2];
    bit          m_pv  [2];
    logic [31:0] m_pd  [2];
    bit          m_ph  [2];
    logic [31:0] m_hold[2];
    bit          exp_v [2][NC];
    logic [31:0] exp_d [2][NC];
    bit          exp_l [2][NC];
    bit          exp_o [2][NC];
    int          ovr_seen[2];
    logic [31:0] got [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_busy[d] = -1; m_pv[d] = 0; m_pd[d] = '0;
            m_ph[d] = 0; m_hold[d] = '0;
            for (int c = 0; c < NC; c++) begin
                exp_v[d][c] = 0; exp_l[d][c] = 0; exp_o[d][c] = 0; exp_d[d][c] = '0;
            end
        end
    endtask

    // A stored sample that leaves D samples in store schedules a whole window read-out.
    task automatic commit(input int d, input logic [31:0] x);
        hist[d][m_n[d]] = x;
        m_n[d]++;
        if (m_n[d] >= D) begin
            for (int i = 0; i < D; i++) begin
                exp_v[d][(cyc + 1 + i) % NC] = 1;
                exp_d[d][(cyc + 1 + i) % NC] = hist[d][m_n[d] - D + i];
            end
            exp_l[d][(cyc + D) % NC] = 1;
            m_busy[d] = cyc + D;
        end
    endtask

    task automatic model_step(input int d, input bit strobe, input logic [31:0] x, input bit dec);
        bit acc;
        acc = strobe && (!dec || !m_ph[d]);
        if (strobe) m_ph[d] = !m_ph[d];
        if (cyc > m_busy[d]) begin
            if (m_pv[d]) begin
                commit(d, m_pd[d]);
                m_pv[d] = acc;
                if (acc) m_pd[d] = x;
            end else if (acc) begin
                commit(d, x);
            end
        end else if (acc) begin
            if (m_pv[d]) exp_o[d][cyc % NC] = 1;
            else begin m_pv[d] = 1; m_pd[d] = x; end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            model_step(0, wrt_a, data_a, 1'b0);
            model_step(1, wrt_b, {16'h0, data_b}, 1'b1);
        end
    end

    always @(negedge rst_n) model_reset();

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] o, eo;
            logic s, l, f, v;
            int c;
            c = cyc % NC;
            o = (d == 0) ? out_a : {16'h0, out_b};
            s = (d == 0) ? seq_a : seq_b;
            l = (d == 0) ? last_a : last_b;
            f = (d == 0) ? full_a : full_b;
            v = (d == 0) ? ovr_a : ovr_b;
            if (exp_v[d][c]) m_hold[d] = exp_d[d][c];
            eo = m_hold[d];
            chk(d == 0 ? "a.sequencing" : "b.sequencing", 32'(s), 32'(exp_v[d][c]));
            chk(d == 0 ? "a.smpl_out" : "b.smpl_out", o, eo);
            chk(d == 0 ? "a.smpl_last" : "b.smpl_last", 32'(l), 32'(exp_l[d][c]));
            chk(d == 0 ? "a.full" : "b.full", 32'(f), 32'(m_n[d] >= D));
            chk(d == 0 ? "a.overrun" : "b.overrun", 32'(v), 32'(exp_o[d][c]));
            if (v) ovr_seen[d]++;
        end
    end

    task automatic write(input int d, input logic [15:0] n);
        @(negedge clk);
        if (d == 0) begin wrt_a = 1'b1; data_a = {16'hFFFF - n, n}; end
        else begin wrt_b = 1'b1; data_b = n; end
        @(negedge clk);
        wrt_a = 1'b0; wrt_b = 1'b0;
    endtask

    function automatic logic seq_of(input int d);
        return (d == 0) ? seq_a : seq_b;
    endfunction

    task automatic wait_seq(input int d, output bit ok);
        int t = 0;
        @(negedge clk);
        while (!seq_of(d) && t < 100) begin @(negedge clk); t++; end
        ok = seq_of(d);
    endtask

    task automatic collect(input int d, input string name);
        bit ok;
        wait_seq(d, ok);
        chk({name, ".started"}, 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < D; i++) begin
                got[i] = (d == 0) ? out_a : {16'h0, out_b};
                if (i < D - 1) @(negedge clk);
            end
        end else begin
            for (int i = 0; i < D; i++) got[i] = 'x;
        end
    endtask

    function automatic logic [31:0] pk(input int n);
        return {16'hFFFF - 16'(n), 16'(n)};
    endfunction

    initial begin
        bit ok;
        model_reset();
        ovr_seen[0] = 0; ovr_seen[1] = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.outputs_a", {out_a[15:0], 12'h0, seq_a, last_a, full_a, ovr_a}, 32'h0);
        chk("reset.outputs_b", {out_b, 12'h0, seq_b, last_b, full_b, ovr_b}, 32'h0);
        #2 rst_n = 1'b1;

        for (int n = 1; n <= 7; n++) write(0, 16'(n));
        chk("fill7.full", 32'(full_a), 32'd0);
        fork
            collect(0, "seq1");
            write(0, 16'd8);
        join
        for (int i = 0; i < D; i++) chk("seq1.data", got[i], pk(i + 1));
        chk("seq1.full", 32'(full_a), 32'd1);

        repeat (3) @(negedge clk);
        fork
            collect(0, "seq2");
            write(0, 16'd9);
        join
        for (int i = 0; i < D; i++) chk("seq2.data", got[i], pk(i + 2));

        repeat (3) @(negedge clk);
        fork
            collect(0, "seq3");
            begin
                write(0, 16'd10);
                wait_seq(0, ok);
                write(0, 16'd11);
                write(0, 16'd12);
            end
        join
        for (int i = 0; i < D; i++) chk("seq3.data", got[i], pk(i + 3));
        collect(0, "seq4");
        for (int i = 0; i < D; i++) chk("seq4.data", got[i], pk(i + 4));
        chk("seq4.overrun_pulses", 32'(ovr_seen[0]), 32'd1);

        for (int n = 1; n <= 14; n++) write(1, 16'(n));
        chk("dec.full_before", 32'(full_b), 32'd0);
        fork
            collect(1, "dec");
            begin write(1, 16'd15); write(1, 16'd16); end
        join
        for (int i = 0; i < D; i++) chk("dec.data", got[i], 32'(2 * i + 1));
        repeat (12) @(negedge clk);
        chk("dec.overrun_pulses", 32'(ovr_seen[1]), 32'd0);

        repeat (3) @(negedge clk);
        write(0, 16'd13);
        wait_seq(0, ok);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.out", out_a, 32'h0);
        chk("midreset.flags", {28'h0, seq_a, last_a, full_a, ovr_a}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 21; n <= 27; n++) write(0, 16'(n));
        chk("refill7.full", 32'(full_a), 32'd0);
        fork
            collect(0, "post_reset");
            write(0, 16'd28);
        join
        for (int i = 0; i < D; i++) chk("post_reset.data", got[i], pk(i + 21));
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
